rdc_event_logger: RTL

Event logger directly downstream of the Request Duration Counter. It watches the RDC's sticky per-core/per-event interruption vector and detects each newly raised bit. For each one it records which core and event offended, a timestamp and the current high watermark in a small show-ahead FIFO. Software, or the bus wrapper, drains the FIFO with a valid/pop handshake, so it learns the order of offences, not just the final OR'ed interrupt.

---
 rtl/rdc_pkg.sv | 25 ++
 rtl/rdc_log_fifo.sv | 58 +++++
 rtl/rdc_event_logger.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rdc_pkg.sv
// Shared sizing helpers and the default log-entry layout for the RDC event logger.
package rdc_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_CORES_DEF       = 4;
    localparam int CORE_EVENTS_DEF   = 2;
    localparam int WEIGHTS_WIDTH_DEF = 8;
    localparam int TS_WIDTH_DEF      = 32;
    localparam int FIFO_DEPTH_DEF    = 8;

    localparam int N_COUNTERS  = N_CORES_DEF * CORE_EVENTS_DEF;
    localparam int CORE_IDX_W  = idx_width(N_CORES_DEF);
    localparam int EVENT_IDX_W = idx_width(CORE_EVENTS_DEF);

    typedef struct packed {
        logic [CORE_IDX_W-1:0]        core;
        logic [EVENT_IDX_W-1:0]       event_id;
        logic [TS_WIDTH_DEF-1:0]      timestamp;
        logic [WEIGHTS_WIDTH_DEF-1:0] watermark;
    } rdc_log_entry_t;

endpackage

// File: rtl/rdc_log_fifo.sv
// Show-ahead synchronous FIFO of log entries; pointers carry one extra wrap bit.
module rdc_log_fifo
    import rdc_pkg::*;
#(
    parameter type ENTRY_T = rdc_log_entry_t,
    parameter int  DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  ENTRY_T                 push_data_i,
    output ENTRY_T                 head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    ENTRY_T      r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_do_pop;
    logic        w_do_push;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign empty_o   = (w_count == '0);
    assign full_o    = (w_count == (AW+1)'(DEPTH));
    assign count_o   = w_count;
    assign w_do_pop  = pop_i && !empty_o && !flush_i;
    assign w_do_push = push_i && (!full_o || w_do_pop) && !flush_i;

    // Head is masked while empty so stale storage never reaches the outputs.
    assign head_o = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; only the pointers need one to define emptiness.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rdc_event_logger.sv
// Logs each newly raised RDC interruption bit (core, event, timestamp, watermark)
// into a show-ahead FIFO, one entry per cycle in index-priority order.
module rdc_event_logger
    import rdc_pkg::*;
#(
    parameter int N_CORES       = N_CORES_DEF,
    parameter int CORE_EVENTS   = CORE_EVENTS_DEF,
    parameter int WEIGHTS_WIDTH = WEIGHTS_WIDTH_DEF,
    parameter int TS_WIDTH      = TS_WIDTH_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                                                  clk_i,
    input  logic                                                  rstn_i,
    input  logic                                                  enable_i,
    input  logic                                                  clear_i,
    input  logic [N_CORES-1:0][CORE_EVENTS-1:0]                   interruption_vector_i,
    input  logic [N_CORES-1:0][CORE_EVENTS-1:0][WEIGHTS_WIDTH-1:0] watermark_i,
    input  logic                                                  pop_i,
    output logic                                                  entry_valid_o,
    output logic [idx_width(N_CORES)-1:0]                         entry_core_o,
    output logic [idx_width(CORE_EVENTS)-1:0]                     entry_event_o,
    output logic [TS_WIDTH-1:0]                                   entry_timestamp_o,
    output logic [WEIGHTS_WIDTH-1:0]                              entry_watermark_o,
    output logic [$clog2(FIFO_DEPTH):0]                           count_o,
    output logic                                                  lost_o
);
    localparam int CORE_W = idx_width(N_CORES);
    localparam int EVT_W  = idx_width(CORE_EVENTS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef logic [N_CORES-1:0][CORE_EVENTS-1:0] vec_t;

    typedef struct packed {
        logic [CORE_W-1:0]        core;
        logic [EVT_W-1:0]         event_id;
        logic [TS_WIDTH-1:0]      timestamp;
        logic [WEIGHTS_WIDTH-1:0] watermark;
    } entry_t;

    vec_t                     r_prev;
    vec_t                     r_pending;
    logic [TS_WIDTH-1:0]      r_ts;
    logic                     r_lost;

    vec_t                     w_new;
    vec_t                     w_cand;
    vec_t                     w_sel_mask;
    logic                     w_found;
    logic [CORE_W-1:0]        w_sel_core;
    logic [EVT_W-1:0]         w_sel_evt;
    logic [WEIGHTS_WIDTH-1:0] w_sel_wm;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic [CNT_W-1:0]         w_count;
    entry_t                   w_push_entry;
    entry_t                   w_head;

    assign w_new  = interruption_vector_i & ~r_prev;
    assign w_cand = r_pending | w_new;

    // Scan from the highest flat index down so the lowest set index is the one left standing.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_found    = 1'b0;
        w_sel_core = '0;
        w_sel_evt  = '0;
        w_sel_wm   = '0;
        w_sel_mask = '0;
        for (int c = N_CORES - 1; c >= 0; c--) begin
            for (int e = CORE_EVENTS - 1; e >= 0; e--) begin
                if (w_cand[c][e]) begin
                    w_found          = 1'b1;
                    w_sel_core       = CORE_W'(c);
                    w_sel_evt        = EVT_W'(e);
                    w_sel_wm         = watermark_i[c][e];
                    w_sel_mask       = '0;
                    w_sel_mask[c][e] = 1'b1;
                end
            end
        end
    end

    // A pop on a full FIFO frees the slot the same-edge push lands in.
    assign w_pop  = pop_i && !w_empty && !clear_i;
    assign w_push = enable_i && !clear_i && w_found && (!w_full || w_pop);

    assign w_push_entry = '{core: w_sel_core, event_id: w_sel_evt,
                            timestamp: r_ts, watermark: w_sel_wm};

    rdc_log_fifo #(
        .ENTRY_T (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (clear_i),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_data_i (w_push_entry),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .count_o     (w_count)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_ts      <= '0;
            r_lost    <= 1'b0;
        end else begin
            if (enable_i) r_ts <= r_ts + 1'b1;

            if (clear_i) begin
                r_prev    <= '0;
                r_pending <= '0;
                r_lost    <= 1'b0;
            end else if (!enable_i) begin
                // Detections still waiting when the enable window closes are discarded.
                r_prev    <= '0;
                r_pending <= '0;
                if (r_pending != '0) r_lost <= 1'b1;
            end else begin
                r_prev    <= interruption_vector_i;
                r_pending <= w_push ? (w_cand & ~w_sel_mask) : w_cand;
            end
        end
    end

    assign entry_valid_o     = !w_empty;
    assign entry_core_o      = w_head.core;
    assign entry_event_o     = w_head.event_id;
    assign entry_timestamp_o = w_head.timestamp;
    assign entry_watermark_o = w_head.watermark;
    assign count_o           = w_count;
    assign lost_o            = r_lost;

endmodule
